// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind a UART receiver: first-word fall-through, sticky overflow flag,
// optional running checksum of accepted bytes (enabled by defining UART_RX_FIFO_CHECKSUM_EN).
module uart_rx_fifo #(
   parameter int depth = 16
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     tock_in_valid,
   input  logic [7:0]               tock_in_data,
   input  logic                     tock_out_ready,
   input  logic                     tock_clear,
   output logic                     get_out_valid_ret,
   output logic [7:0]               get_out_data_ret,
   output logic [$clog2(depth):0]   get_count_ret,
   output logic                     get_full_ret,
   output logic                     get_overflow_ret,
   output logic [31:0]              get_checksum_ret
);

   localparam int AW = $clog2(depth);
   localparam int CW = AW + 1;

   logic [7:0]    mem_q [depth];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          empty, full, push, pop;

   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   always_comb begin
      empty      = (count_q == '0);
      full       = (count_q == CW'(depth));
      pop        = !empty && tock_out_ready;
      push       = tock_in_valid && (!full || pop);
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
      if (tock_in_valid && !push) overflow_d = 1'b1;
      else if (tock_clear)        overflow_d = 1'b0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is deliberately not reset; the write is still held off while reset is asserted.
   always_ff @(posedge clock) begin
      if (push && reset_n) mem_q[wr_ptr_q] <= tock_in_data;
   end

`ifdef UART_RX_FIFO_CHECKSUM_EN
   logic [31:0] checksum_q, checksum_d;

   always_comb begin
      checksum_d = checksum_q;
      if (tock_clear)  checksum_d = push ? {24'h0, tock_in_data} : 32'h0;
      else if (push)   checksum_d = checksum_q + {24'h0, tock_in_data};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) checksum_q <= '0;
      else          checksum_q <= checksum_d;
   end

   assign get_checksum_ret = checksum_q;
`else
   assign get_checksum_ret = 32'h0;
`endif

   // Head byte is masked to zero when empty so reset reads 0x00 without clearing storage.
   assign get_out_valid_ret = !empty;
   assign get_out_data_ret  = empty ? 8'h00 : mem_q[rd_ptr_q];
   assign get_count_ret     = count_q;
   assign get_full_ret      = full;
   assign get_overflow_ret  = overflow_q;

endmodule
